sha_tail_packer_128: RTL and testbench

Assembles the 128-bit tail of an 80-byte block header (merkle-root tail, time, bits, nonce) from a 32-bit word stream. Writes it into the 128-bit block store through a one-cycle `write_en` pulse. Then sweeps the nonce word on request, re-issuing the updated block for each new nonce. Sits directly upstream of the 128-bit block store, which feeds the second-block message expander of the double SHA-256 core.

---
 rtl/sha_tail_packer_128.sv | 88 ++++++++
 tb/tb_sha_tail_packer_128.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sha_tail_packer_128.sv
// Packs four 32-bit header words into the 128-bit block tail, writes it to the
// block store, then sweeps the nonce word one write per step request.
module sha_tail_packer_128 #(
  parameter bit NONCE_SWAP = 1'b0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         word_valid,
  input  logic [31:0]  word_in,
  output logic         word_ready,
  input  logic         restart,
  input  logic         nonce_step,
  output logic [127:0] block_out,
  output logic         write_en,
  output logic         nonce_wrap
);

  typedef enum logic [1:0] {FILL, WRITE, HOLD} state_t;

  state_t      r_state;
  logic [1:0]  r_word_cnt;
  logic [31:0] w_nonce_cur;
  logic [31:0] w_nonce_inc;
  logic [31:0] w_nonce_nxt;
  logic        w_nonce_max;

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // Swapping is its own inverse, so the same function maps in and out.
  assign w_nonce_cur = NONCE_SWAP ? bswap(block_out[31:0]) : block_out[31:0];
  assign w_nonce_inc = w_nonce_cur + 32'd1;
  assign w_nonce_nxt = NONCE_SWAP ? bswap(w_nonce_inc) : w_nonce_inc;
  assign w_nonce_max = (block_out[31:0] == 32'hFFFF_FFFF);

  assign word_ready = (r_state == FILL);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= FILL;
      r_word_cnt <= 2'd0;
      block_out  <= '0;
      write_en   <= 1'b0;
      nonce_wrap <= 1'b0;
    end else begin
      write_en   <= 1'b0;
      nonce_wrap <= 1'b0;
      if (restart) begin
        r_state    <= FILL;
        r_word_cnt <= 2'd0;
      end else begin
        case (r_state)
          FILL: begin
            if (word_valid) begin
              case (r_word_cnt)
                2'd0: block_out[127:96] <= word_in;
                2'd1: block_out[95:64]  <= word_in;
                2'd2: block_out[63:32]  <= word_in;
                default: block_out[31:0] <= word_in;
              endcase
              r_word_cnt <= r_word_cnt + 2'd1;
              if (r_word_cnt == 2'd3) begin
                r_state  <= WRITE;
                write_en <= 1'b1;
              end
            end
          end
          WRITE: r_state <= HOLD;
          HOLD: begin
            if (nonce_step) begin
              if (w_nonce_max) begin
                nonce_wrap <= 1'b1;
                r_state    <= FILL;
              end else begin
                block_out[31:0] <= w_nonce_nxt;
                write_en        <= 1'b1;
                r_state         <= WRITE;
              end
            end
          end
          default: r_state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha_tail_packer_128.sv
// Directed bench for sha_tail_packer_128; a plain and a byte-swapped instance share stimulus.
module tb_sha_tail_packer_128;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         word_valid = 1'b0;
  logic [31:0]  word_in = '0;
  logic         restart = 1'b0;
  logic         nonce_step = 1'b0;
  logic [127:0] bo0, bo1;
  logic         wr0, wr1, we0, we1, nw0, nw1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  sha_tail_packer_128 #(.NONCE_SWAP(1'b0)) u_dut0 (
    .CLK(CLK), .RST(RST), .word_valid(word_valid), .word_in(word_in),
    .word_ready(wr0), .restart(restart), .nonce_step(nonce_step),
    .block_out(bo0), .write_en(we0), .nonce_wrap(nw0));

  sha_tail_packer_128 #(.NONCE_SWAP(1'b1)) u_dut1 (
    .CLK(CLK), .RST(RST), .word_valid(word_valid), .word_in(word_in),
    .word_ready(wr1), .restart(restart), .nonce_step(nonce_step),
    .block_out(bo1), .write_en(we1), .nonce_wrap(nw1));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    word_valid = 1'b1;
    word_in    = w;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic fill4(input logic [31:0] a, b, c, d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic step();
    nonce_step = 1'b1;
    tick();
    nonce_step = 1'b0;
  endtask

  logic [127:0] hold0, hold1;

  initial begin
    tick(); tick();
    RST = 1'b0;

    // reset asserted mid-fill with two words loaded
    send(32'hAAAA0001); send(32'hAAAA0002);
    #2 RST = 1'b1;
    #1;
    chk("rst_block", bo0, '0);
    chk("rst_we", {127'd0, we0}, 128'd0);
    chk("rst_wrap", {127'd0, nw0}, 128'd0);
    chk("rst_ready", {127'd0, wr0}, 128'd1);
    word_valid = 1'b1; word_in = 32'h5555_5555;
    tick();
    chk("rst_no_accept", bo0, '0);
    word_valid = 1'b0;
    RST = 1'b0;

    fill4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    chk("fill_we", {127'd0, we0}, 128'd1);
    chk("fill_block", bo0, 128'h11111111_22222222_33333333_44444444);
    // fifth word during WRITE is refused
    chk("write_ready", {127'd0, wr0}, 128'd0);
    word_valid = 1'b1; word_in = 32'hDEADBEEF;
    tick();
    chk("hold_we_single", {127'd0, we0}, 128'd0);
    chk("hold_ready", {127'd0, wr0}, 128'd0);
    tick();
    word_valid = 1'b0;
    chk("hold_block_kept", bo0, 128'h11111111_22222222_33333333_44444444);

    // gapped fill after restart
    restart = 1'b1; tick(); restart = 1'b0;
    chk("restart_ready", {127'd0, wr0}, 128'd1);
    send(32'hCAFE0000); tick();
    send(32'h12345678); tick(); tick();
    send(32'h9ABCDEF0); tick();
    chk("gap_no_we", {127'd0, we0}, 128'd0);
    chk("gap_ready", {127'd0, wr0}, 128'd1);
    send(32'h000000FF);
    chk("gap_we", {127'd0, we0}, 128'd1);
    chk("gap_block", bo0, 128'hCAFE0000_12345678_9ABCDEF0_000000FF);
    tick();

    // three steps from 000000FF
    step();
    chk("step1_we", {127'd0, we0}, 128'd1);
    chk("step1_blk0", bo0, 128'hCAFE0000_12345678_9ABCDEF0_00000100);
    chk("step1_blk1", bo1, 128'hCAFE0000_12345678_9ABCDEF0_010000FF);
    tick();
    chk("step1_we_off", {127'd0, we0}, 128'd0);
    step();
    chk("step2_blk0", bo0, 128'hCAFE0000_12345678_9ABCDEF0_00000101);
    chk("step2_blk1", bo1, 128'hCAFE0000_12345678_9ABCDEF0_020000FF);
    tick();
    step();
    chk("step3_we", {127'd0, we0}, 128'd1);
    chk("step3_blk0", bo0, 128'hCAFE0000_12345678_9ABCDEF0_00000102);
    chk("step3_blk1", bo1, 128'hCAFE0000_12345678_9ABCDEF0_030000FF);
    tick();

    // step held continuously: one block every two cycles
    nonce_step = 1'b1;
    tick();
    chk("cont_we_a", {127'd0, we0}, 128'd1);
    chk("cont_blk_a", bo0, 128'hCAFE0000_12345678_9ABCDEF0_00000103);
    tick();
    chk("cont_we_gap", {127'd0, we0}, 128'd0);
    tick();
    chk("cont_blk_b", bo0, 128'hCAFE0000_12345678_9ABCDEF0_00000104);
    nonce_step = 1'b0;
    tick();

    // byte-swapped increment
    restart = 1'b1; tick(); restart = 1'b0;
    fill4(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'hFF000000);
    tick();
    step();
    chk("swap_blk0", bo0, 128'h01020304_05060708_090A0B0C_FF000001);
    chk("swap_blk1", bo1, 128'h01020304_05060708_090A0B0C_00010000);
    chk("swap_we1", {127'd0, we1}, 128'd1);
    tick();

    // wrap at maximum nonce
    restart = 1'b1; tick(); restart = 1'b0;
    fill4(32'hA0A0A0A0, 32'hB0B0B0B0, 32'hC0C0C0C0, 32'hFFFFFFFF);
    tick();
    step();
    chk("wrap_pulse0", {127'd0, nw0}, 128'd1);
    chk("wrap_pulse1", {127'd0, nw1}, 128'd1);
    chk("wrap_no_we", {126'd0, we0, we1}, 128'd0);
    chk("wrap_block", bo0, 128'hA0A0A0A0_B0B0B0B0_C0C0C0C0_FFFFFFFF);
    chk("wrap_ready", {127'd0, wr0}, 128'd1);
    tick();
    chk("wrap_pulse_off", {127'd0, nw0}, 128'd0);

    // restart beats nonce_step in HOLD
    fill4(32'h10000001, 32'h20000002, 32'h30000003, 32'h40000004);
    tick();
    hold0 = bo0;
    restart = 1'b1; nonce_step = 1'b1;
    tick();
    restart = 1'b0; nonce_step = 1'b0;
    chk("rs_step_no_we", {127'd0, we0}, 128'd0);
    chk("rs_step_ready", {127'd0, wr0}, 128'd1);
    chk("rs_step_block", bo0, 128'h10000001_20000002_30000003_40000004);

    // restart beats word_valid in FILL
    restart = 1'b1;
    send(32'hBADBAD00);
    restart = 1'b0;
    chk("rs_word_block", bo0, 128'h10000001_20000002_30000003_40000004);
    send(32'h0000000A); send(32'h0000000B); send(32'h0000000C);
    chk("rs_cnt_no_we", {127'd0, we0}, 128'd0);
    send(32'h0000000D);
    chk("rs_cnt_we", {127'd0, we0}, 128'd1);
    chk("rs_cnt_block", bo0, 128'h0000000A_0000000B_0000000C_0000000D);

    // restart during WRITE keeps the pulse already out
    hold1 = bo0;
    restart = 1'b1;
    chk("rs_write_we", {127'd0, we0}, 128'd1);
    tick();
    restart = 1'b0;
    chk("rs_write_we_off", {127'd0, we0}, 128'd0);
    chk("rs_write_ready", {127'd0, wr0}, 128'd1);
    chk("rs_write_block", bo0, hold1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // pulses never overlap and never last two cycles
  logic p_we, p_nw;
  always @(negedge CLK) begin
    if (!RST) begin
      if ((we0 && nw0) || (we0 && p_we) || (nw0 && p_nw)) begin
        errors++;
        $display("FAIL pulse_shape: we=%b wrap=%b prev_we=%b prev_wrap=%b expected single isolated pulses",
                 we0, nw0, p_we, p_nw);
      end
    end
    p_we = we0;
    p_nw = nw0;
  end

endmodule
